uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 tx block. Adds compile-time data width, parity mode, stop-bit count, a valid/ready input handshake and an asynchronous active-low reset. Sits between a byte source (CPU bridge, logger, test pattern generator) and the FPGA serial TX pin. The same RTL covers all common frame formats.

Parameters:
BAUD_RATE, 9600, line bit rate in bits/s
CLOCK_HZ, 12_000_000, clock frequency; CYCLES_PER_BIT = CLOCK_HZ / BAUD_RATE (integer division), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits, legal 1 or 2
FIFO_DEPTH, 4, entries in the optional input FIFO; power of two, >= 2; ignored unless UART_TX_FIFO_EN is defined

Ports:
clock  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
valid  in  1  data word offered
ready  out  1  block accepts the word this cycle
data  in  DATA_BITS  word to send, LSB first
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of last stop bit
pin  out  1  serial TX line, registered
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; port exists only with UART_TX_FIFO_EN

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (reset_n = 0): takes effect immediately, not at a clock edge. pin = 1, busy = 0, done = 0, state IDLE, counters = 0, FIFO empty, level = 0. ready = 1 while in reset, but no word is accepted until reset_n is high at a rising clock edge.
- Handshake: a word is accepted at a rising edge where valid & ready. data is captured into an internal shift register on that edge. valid without ready is ignored, and the word is not held pending.
- ready (no FIFO) = state == IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - pin = 1, busy = 0.
  - On accept: go to START and set busy = 1 on the same edge.
  - pin drives 0 from the next edge, so latency from accept edge to start bit is 1 clock.
- START: pin = 0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - pin = data[index] for CYCLES_PER_BIT cycles per bit, LSB first.
  - After bit DATA_BITS-1: go to PARITY if PARITY != 0, else go to STOP.
- PARITY:
  - pin = XOR of the DATA_BITS captured bits (even), or its inverse (odd), for CYCLES_PER_BIT cycles; then go to STOP.
- STOP:
  - pin = 1 for STOP_BITS * CYCLES_PER_BIT cycles.
  - On the final cycle's edge: go to IDLE, busy = 0, done = 1 for exactly one cycle.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CYCLES_PER_BIT cycles.
- Back-to-back frames: a word is accepted at the earliest on the IDLE cycle after done. The minimum gap between frames is 1 clock of extra high time beyond the stop bits.
- Counter widths: the cycle counter is $clog2(CYCLES_PER_BIT)+1 bits and wraps to 0 at each bit boundary. The bit index is $clog2(DATA_BITS)+1 bits.
- Reset mid-frame: the frame is aborted, pin returns high immediately and done does not pulse.
- Changes on data while busy have no effect on the frame in flight.
- Illegal parameter values stop elaboration via a generate-time $error.

Optional Feature:
UART_TX_FIFO_EN:
- Defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the FSM, and ready = !full.
  - Push on valid & ready. The FSM pops when in IDLE and the FIFO is not empty; the popped word starts the frame as in the accept rule above.
  - Push and pop on the same edge leave level unchanged.
  - level reports occupancy.
  - busy = (FSM not IDLE) | (FIFO not empty).
- Undefined: no FIFO, ready = IDLE, and the level port is absent.

Test Plan:
All tests use CLOCK_HZ = 12_000_000 and BAUD_RATE = 1_000_000, so CYCLES_PER_BIT = 12.
1. 8N1, accept 0xA5 at edge T -> pin low over T+1..T+12, then data bits 1,0,1,0,0,1,0,1 for 12 cycles each, stop high for 12 cycles; done pulses once at T+120; busy high T..T+119; ready low throughout.
2. DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, data 0x53 -> bits 1,1,0,0,1,0,1, parity 0, stop 24 cycles, frame 132 cycles; with PARITY = 2 the parity bit = 1.
3. valid held high with 0x11 then 0x22 -> second start bit begins exactly 2 clocks after the done pulse for 0x11; no word is lost or duplicated.
4. reset_n pulsed low during data bit 3 of 0xFF -> pin = 1 and busy = 0 immediately, no done pulse; a following 0x3C frame is bit-exact.
5. valid pulsed with 0x00 while busy (no FIFO) -> ignored; the in-flight frame is unchanged and no extra frame follows.
6. UART_TX_FIFO_EN with FIFO_DEPTH = 4: push 0x01..0x04 on 4 consecutive cycles -> all accepted; level peaks at 3 (first word popped) and ready stays high; pushing 0x05..0x08 while the first frame runs -> ready falls when level = 4; output order is 0x01..0x08.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input, parity and 1/2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO (and the level port) in front of the FSM.
module uart_tx_frame #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_HZ   = 12_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 valid,
    output logic                 ready,
    input  logic [DATA_BITS-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 pin
`ifdef UART_TX_FIFO_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] level
`endif
);

    localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT) + 1;
    localparam int IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx_frame: CLOCK_HZ / BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
`ifdef UART_TX_FIFO_EN
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
        end
`endif
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 busy_fsm;
    logic                 start_frame;
    logic [DATA_BITS-1:0] next_word;

`ifdef UART_TX_FIFO_EN
    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic                 push;
    logic                 pop;

    // The FSM drains the FIFO whenever it is idle; the head word starts the next frame.
    assign ready       = (level != (ADDR_W + 1)'(FIFO_DEPTH));
    assign push        = valid & ready;
    assign pop         = (state == S_IDLE) && (level != '0);
    assign start_frame = pop;
    assign next_word   = fifo_mem[rd_ptr];
    assign busy        = busy_fsm | (level != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= data;
    end
`else
    assign ready       = (state == S_IDLE);
    assign start_frame = valid & ready;
    assign next_word   = data;
    assign busy        = busy_fsm;
`endif

    // pin is registered from the current state, so it trails the state by one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cycle_cnt  <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            busy_fsm   <= 1'b0;
            done       <= 1'b0;
            pin        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    pin <= 1'b1;
                    if (start_frame) begin
                        shift_reg  <= next_word;
                        parity_bit <= (^next_word) ^ (PARITY == 2);
                        cycle_cnt  <= '0;
                        bit_idx    <= '0;
                        busy_fsm   <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    pin <= 1'b0;
                    if (cycle_cnt == LAST_CYCLE) begin
                        cycle_cnt <= '0;
                        bit_idx   <= '0;
                        state     <= S_DATA;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    pin <= shift_reg[0];
                    if (cycle_cnt == LAST_CYCLE) begin
                        cycle_cnt <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    pin <= parity_bit;
                    if (cycle_cnt == LAST_CYCLE) begin
                        cycle_cnt <= '0;
                        bit_idx   <= '0;
                        state     <= S_STOP;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    pin <= 1'b1;
                    if (cycle_cnt == LAST_CYCLE) begin
                        cycle_cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx  <= '0;
                            busy_fsm <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                default: begin
                    pin   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: three transmitters (8N1, 7E2, 7O2) checked against a frame-level model.
// Expected words are queued at stimulus time; a pin monitor per instance pops and compares.
module tb_uart_tx_frame;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int NDUT   = 3;
    localparam int CFG_DB   [NDUT] = '{8, 7, 7};
    localparam int CFG_PAR  [NDUT] = '{0, 1, 2};
    localparam int CFG_STOP [NDUT] = '{1, 2, 2};
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [NDUT-1:0] valid_v;
    logic [NDUT-1:0] ready_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] pin_v;
    logic [8:0] data_v [NDUT];
`ifdef UART_TX_FIFO_EN
    logic [2:0] level_v [NDUT];
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] exp_q [NDUT][$];
    int in_frame      [NDUT];
    int last_start    [NDUT];
    int last_done     [NDUT];
    int last_gap      [NDUT];
    int frames_done   [NDUT];
    int spurious_done [NDUT];
    int sent          [NDUT];
    int aborted       [NDUT];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: the pin level for each bit period of a frame, LSB first.
    function automatic int frameBits(input int g, input logic [8:0] w, output logic [15:0] bits);
        int n = 0;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < CFG_DB[g]; i++) begin
            bits[n] = w[i];
            ones += int'(w[i]);
            n++;
        end
        if (CFG_PAR[g] != 0) begin
            bits[n] = ((ones % 2) == 1) ^ (CFG_PAR[g] == 2);
            n++;
        end
        for (int s = 0; s < CFG_STOP[g]; s++) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int g, input logic [8:0] w, output int acc);
        int n = 0;
        @(negedge clock);
        while (!ready_v[g] && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checkOutput($sformatf("ready_wait%0d", g), int'(ready_v[g]), 1);
        data_v[g]  = w;
        valid_v[g] = 1'b1;
        exp_q[g].push_back(w & 9'((1 << CFG_DB[g]) - 1));
        sent[g]++;
        @(negedge clock);
        valid_v[g] = 1'b0;
        acc = cyc;
    endtask

    task automatic waitDrain(input int g);
        int n = 0;
        while ((exp_q[g].size() != 0 || in_frame[g] != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checkOutput($sformatf("drain%0d", g), exp_q[g].size() + in_frame[g], 0);
    endtask

    task automatic randomBurst(input int g, input int count);
        int acc;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 15)) @(negedge clock);
            applyStimulus(g, 9'($urandom), acc);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DB = CFG_DB[g];

        uart_tx_frame #(
            .BAUD_RATE (BAUD),
            .CLOCK_HZ  (CLK_HZ),
            .DATA_BITS (DB),
            .PARITY    (CFG_PAR[g]),
            .STOP_BITS (CFG_STOP[g]),
            .FIFO_DEPTH(4)
        ) dut (
            .clock  (clock),
            .reset_n(reset_n),
            .valid  (valid_v[g]),
            .ready  (ready_v[g]),
            .data   (data_v[g][DB-1:0]),
            .busy   (busy_v[g]),
            .done   (done_v[g]),
            .pin    (pin_v[g])
`ifdef UART_TX_FIFO_EN
            ,
            .level  (level_v[g])
`endif
        );

        // Monitor: a falling pin starts a frame; every sample of it is compared with the model.
        initial begin : monitor
            logic [15:0] want;
            logic [15:0] got;
            logic [8:0]  w;
            int nbits;
            int last;
            int bad;
            bit ctrl_bad;
            bit was_aborted;
            in_frame[g] = 0;
            last_done[g] = -1000;
            forever begin
                @(negedge clock);
                if (!reset_n) continue;
                if (pin_v[g] !== 1'b0) begin
                    if (done_v[g] !== 1'b0) spurious_done[g]++;
                    continue;
                end
                in_frame[g]   = 1;
                last_start[g] = cyc;
                last_gap[g]   = cyc - last_done[g];
                if (exp_q[g].size() == 0) begin
                    checkOutput($sformatf("unexpected_frame%0d", g), 1, 0);
                    w = '0;
                end else begin
                    w = exp_q[g].pop_front();
                end
                nbits = frameBits(g, w, want);
                last = nbits * CPB - 1;
                got = '0;
                bad = 0;
                ctrl_bad = 1'b0;
                was_aborted = 1'b0;
                for (int s = 0; s <= last; s++) begin
                    if (s > 0) @(negedge clock);
                    if (!reset_n) begin
                        was_aborted = 1'b1;
                        break;
                    end
                    if (pin_v[g] !== want[s / CPB]) bad++;
                    if ((s % CPB) == CPB / 2) got[s / CPB] = pin_v[g];
                    if (done_v[g] !== (s == last)) ctrl_bad = 1'b1;
`ifdef UART_TX_FIFO_EN
                    if (s != last && busy_v[g] !== 1'b1) ctrl_bad = 1'b1;
`else
                    if (busy_v[g] !== (s != last) || ready_v[g] !== (s == last)) ctrl_bad = 1'b1;
`endif
                end
                if (!was_aborted) begin
                    checks += 2;
                    if (bad != 0) begin
                        errors++;
                        $display("[TB] FAIL frame%0d word=%h: got bits %b required %b, %0d bad samples",
                                 g, w, got, want, bad);
                    end
                    if (ctrl_bad) begin
                        errors++;
                        $display("[TB] FAIL ctrl%0d word=%h: done/busy/ready got wrong timing, required done only on last stop cycle",
                                 g, w);
                    end
                    last_done[g] = cyc;
                    frames_done[g]++;
                end
                in_frame[g] = 0;
            end
        end
    end

    initial begin : watchdog
        #(50000 * 10);
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        int acc;
        int lv;
        int ready_low;
        logic [8:0] rst_words [2];
        rst_words[0] = 9'h0FF;
        rst_words[1] = 9'h000;
        reset_n = 1'b0;
        valid_v = '0;
        for (int g = 0; g < NDUT; g++) begin
            data_v[g] = '0;
            frames_done[g] = 0;
            spurious_done[g] = 0;
            sent[g] = 0;
            aborted[g] = 0;
        end
        repeat (3) @(negedge clock);
        for (int g = 0; g < NDUT; g++) begin
            checkOutput($sformatf("reset_pin%0d", g), int'(pin_v[g]), 1);
            checkOutput($sformatf("reset_busy%0d", g), int'(busy_v[g]), 0);
            checkOutput($sformatf("reset_done%0d", g), int'(done_v[g]), 0);
            checkOutput($sformatf("reset_ready%0d", g), int'(ready_v[g]), 1);
        end
        #2 reset_n = 1'b1;

        $display("[TB] 8N1 frame of 0xA5");
        applyStimulus(0, 9'h0A5, acc);
        waitDrain(0);
        checkOutput("start_latency", last_start[0] - acc, LAT);

        $display("[TB] 7E2 and 7O2 frames of 0x53");
        applyStimulus(1, 9'h053, acc);
        applyStimulus(2, 9'h053, acc);
        waitDrain(1);
        waitDrain(2);

        $display("[TB] back-to-back 0x11, 0x22 with valid held");
        @(negedge clock);
        data_v[0]  = 9'h011;
        valid_v[0] = 1'b1;
        exp_q[0].push_back(9'h011);
        sent[0]++;
        @(negedge clock);
        data_v[0] = 9'h022;
        exp_q[0].push_back(9'h022);
        sent[0]++;
        lv = 0;
        while (!ready_v[0] && lv < 3000) begin
            @(negedge clock);
            lv++;
        end
        @(negedge clock);
        valid_v[0] = 1'b0;
        waitDrain(0);
        checkOutput("b2b_gap", last_gap[0], 2);

        $display("[TB] reset during data bit 3");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, rst_words[k], acc);
            repeat (54) @(negedge clock);
            #2 reset_n = 1'b0;
            aborted[0]++;
            #1;
            checkOutput($sformatf("abort_pin_%0d", k), int'(pin_v[0]), 1);
            checkOutput($sformatf("abort_busy_%0d", k), int'(busy_v[0]), 0);
            checkOutput($sformatf("abort_done_%0d", k), int'(done_v[0]), 0);
`ifdef UART_TX_FIFO_EN
            checkOutput($sformatf("abort_level_%0d", k), int'(level_v[0]), 0);
`endif
            repeat (2) @(negedge clock);
            #2 reset_n = 1'b1;
        end
        applyStimulus(0, 9'h03C, acc);
        waitDrain(0);

`ifndef UART_TX_FIFO_EN
        $display("[TB] valid pulsed while busy is ignored");
        applyStimulus(0, 9'h096, acc);
        repeat (30) @(negedge clock);
        data_v[0]  = 9'h000;
        valid_v[0] = 1'b1;
        @(negedge clock);
        valid_v[0] = 1'b0;
        waitDrain(0);
        repeat (200) @(negedge clock);
`else
        $display("[TB] FIFO fill and overflow back-pressure");
        ready_low = 0;
        lv = 0;
        @(negedge clock);
        for (int i = 1; i <= 5; i++) begin
            if (!ready_v[0]) ready_low++;
            data_v[0]  = 9'(i);
            valid_v[0] = 1'b1;
            exp_q[0].push_back(9'(i));
            sent[0]++;
            @(negedge clock);
            if (i <= 4 && int'(level_v[0]) > lv) lv = int'(level_v[0]);
        end
        valid_v[0] = 1'b0;
        checkOutput("fill_ready_low", ready_low, 0);
        checkOutput("fill_peak_level", lv, 3);
        checkOutput("full_level", int'(level_v[0]), 4);
        checkOutput("full_ready", int'(ready_v[0]), 0);
        for (int i = 6; i <= 8; i++) applyStimulus(0, 9'(i), acc);
        waitDrain(0);
`endif

        $display("[TB] randomized words on all instances");
        fork
            randomBurst(0, 5);
            randomBurst(1, 5);
            randomBurst(2, 5);
        join
        for (int g = 0; g < NDUT; g++) waitDrain(g);
        repeat (20) @(negedge clock);

        for (int g = 0; g < NDUT; g++) begin
            checkOutput($sformatf("frame_count%0d", g), frames_done[g], sent[g] - aborted[g]);
            checkOutput($sformatf("spurious_done%0d", g), spurious_done[g], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
